// File: rtl/dpram_fifo_pkg.sv
// Shared constants, pointer type and flag helpers for the dual-port RAM FIFO controller.
package dpram_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH = 6;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    // Same slot, opposite lap: the writer is a full buffer ahead of the reader.
    function automatic logic ptr_full(ptr_t wr, ptr_t rd);
        return (wr[DEF_ADDR_WIDTH-1:0] == rd[DEF_ADDR_WIDTH-1:0]) &&
               (wr[DEF_ADDR_WIDTH] != rd[DEF_ADDR_WIDTH]);
    endfunction

    // Occupancy; the modulo wrap of the subtraction handles pointer roll-over.
    function automatic ptr_t ptr_level(ptr_t wr, ptr_t rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external simple dual-port RAM (sync write, async read).
// Optional flush input enabled by defining DPRAM_FIFO_FLUSH_EN.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DPRAM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   max_level
);

    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
    logic                full, empty, push, pop, flush_i;

`ifdef DPRAM_FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Package helpers are sized for the default width; other widths use the same math inline.
    if (ADDR_WIDTH == DEF_ADDR_WIDTH) begin : g_pkg_flags
        assign full      = ptr_full(wr_ptr, rd_ptr);
        assign level     = ptr_level(wr_ptr, rd_ptr);
        assign level_nxt = ptr_level(wr_nxt, rd_nxt);
    end else begin : g_gen_flags
        assign full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                           (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        assign level     = wr_ptr - rd_ptr;
        assign level_nxt = wr_nxt - rd_nxt;
    end

    assign empty     = (wr_ptr == rd_ptr);
    // Reset gates readiness combinationally so nothing is accepted while it is held.
    assign in_ready  = !full && !rst && !flush_i;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush_i;

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_wr_data = in_data;
    assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign out_data    = mem_rd_data;

    // Next pointer values; flush drops everything already written.
    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (push) wr_nxt = wr_ptr + 1'b1;
        if (flush_i)  rd_nxt = wr_ptr;
        else if (pop) rd_nxt = rd_ptr + 1'b1;
    end

    // Pointer and high-water registers; max_level saturates naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            max_level <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (level_nxt > max_level) max_level <= level_nxt;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural RAM attached.
module tb_dpram_fifo_ctrl;

    localparam int DW = 14;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          mem_wr_en;
    logic [AW:0]   level, max_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
`ifdef DPRAM_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .level(level), .max_level(max_level)
    );

    // Simple dual-port RAM model: sync write, async read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = mem[mem_rd_addr];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released away from clock edges.
    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        #2;
        rst = 1'b0;
        edge_step();
    endtask

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [DW-1:0] din;
        logic          e_in_ready;
        logic          e_out_valid;
        logic          e_wr_en;
        int            e_waddr;
        int            e_level;
        int            e_out_data;
        int            e_max;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Basic push/pop table: three pushes, pops, push+pop, pop on empty.
        vecs[0] = '{1, 0, 14'h1, 1, 0, 1, 0, 0, -1, 0};
        vecs[1] = '{1, 0, 14'h2, 1, 1, 1, 1, 1,  1, 1};
        vecs[2] = '{1, 0, 14'h3, 1, 1, 1, 2, 2,  1, 2};
        vecs[3] = '{0, 0, 14'h0, 1, 1, 0, 3, 3,  1, 3};
        vecs[4] = '{0, 1, 14'h0, 1, 1, 0, 3, 3,  1, 3};
        vecs[5] = '{0, 1, 14'h0, 1, 1, 0, 3, 2,  2, 3};
        vecs[6] = '{1, 1, 14'h4, 1, 1, 1, 3, 1,  3, 3};
        vecs[7] = '{0, 1, 14'h0, 1, 1, 0, 4, 1,  4, 3};
        vecs[8] = '{0, 1, 14'h0, 1, 0, 0, 4, 0, -1, 3};
        vecs[9] = '{0, 0, 14'h0, 1, 0, 0, 4, 0, -1, 3};

        // Reset state while rst is held.
        #2;
        chk("rst_level", level, 0);
        chk("rst_max", max_level, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        do_reset();
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_data   = vecs[i].din;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
            chk($sformatf("v%0d_wr_en", i), mem_wr_en, vecs[i].e_wr_en);
            chk($sformatf("v%0d_wr_addr", i), mem_wr_addr, vecs[i].e_waddr);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
            chk($sformatf("v%0d_max", i), max_level, vecs[i].e_max);
            if (vecs[i].e_out_data >= 0)
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_out_data);
            edge_step();
        end

        // Fill to full with 0..63, then a 65th attempt must not write.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            @(negedge clk);
            chk($sformatf("fill%0d_wr_addr", i), mem_wr_addr, i);
            chk($sformatf("fill%0d_wr_en", i), mem_wr_en, 1);
            edge_step();
        end
        in_data = DW'(99);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_level", level, 64);
        chk("full_max", max_level, 64);
        chk("full_65th_wr_en", mem_wr_en, 0);
        edge_step();
        chk("full_hold_level", level, 64);

        // From full: pop + push in the same cycle, push refused.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(100);
        @(negedge clk);
        chk("fpp_in_ready", in_ready, 0);
        chk("fpp_wr_en", mem_wr_en, 0);
        chk("fpp_out_data", out_data, 0);
        edge_step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("fpp_level63", level, 63);
        chk("fpp_in_ready_next", in_ready, 1);
        chk("fpp_wrap_addr", mem_wr_addr, 0);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fpp_level64", level, 64);
        chk("fpp_head", out_data, 1);
        chk("fpp_max", max_level, 64);

        // Streaming 200 words with out_ready high: level stays at 1.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 500);
            @(negedge clk);
            chk($sformatf("st%0d_wr_addr", i), mem_wr_addr, i % 64);
            if (i > 0) begin
                chk($sformatf("st%0d_level", i), level, 1);
                chk($sformatf("st%0d_data", i), out_data, i + 499);
            end
            edge_step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("st_last_data", out_data, 699);
        chk("st_rd_addr", mem_rd_addr, 199 % 64);
        edge_step();
        chk("st_drained", out_valid, 0);
        chk("st_max", max_level, 1);
        out_ready = 1'b0;

        // Asynchronous reset mid-stream at level 10.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 7);
            edge_step();
        end
        in_valid = 1'b0;
        chk("ar_level_before", level, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_level", level, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_max", max_level, 0);
        @(negedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 14'h2A;
        #1;
        chk("ar_first_addr", mem_wr_addr, 0);
        chk("ar_first_wr_en", mem_wr_en, 1);
        edge_step();
        in_valid = 1'b0;
        chk("ar_first_data", out_data, 14'h2A);
        chk("ar_level_after", level, 1);

`ifdef DPRAM_FIFO_FLUSH_EN
        // Flush at level 5 with a concurrent push attempt.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            edge_step();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", in_ready, 0);
        chk("fl_wr_en", mem_wr_en, 0);
        edge_step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_level", level, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_max", max_level, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
